// File: rtl/mac_serial_sequencer.sv
// Pin-level sequencer for the 8x8 MAC core. It takes in two serial operands and launches the MAC.
// It then waits for the MAC to finish and streams the result plus carry back out, LSB first.
module mac_serial_sequencer #(
    parameter int OP_WIDTH  = 8,
    parameter int RES_WIDTH = 20,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 ser_a,
    input  logic                 ser_b,
    input  logic                 mac_finish,
    input  logic [RES_WIDTH-1:0] mac_result,
    input  logic                 mac_carry,
    output logic [OP_WIDTH-1:0]  op_a,
    output logic [OP_WIDTH-1:0]  op_b,
    output logic                 mac_start,
    output logic                 in_done,
    output logic                 ser_out,
    output logic                 out_valid,
    output logic                 out_done,
    output logic                 busy,
    output logic                 err,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SHIFT_IN  = 3'd1,
        S_LAUNCH    = 3'd2,
        S_WAIT      = 3'd3,
        S_SHIFT_OUT = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int OUT_LEN = RES_WIDTH + 1;
    localparam int MAX_AB  = (OP_WIDTH > OUT_LEN) ? OP_WIDTH : OUT_LEN;
    localparam int CNT_MAX = (MAX_AB > TIMEOUT) ? MAX_AB : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(OP_WIDTH - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_LEN);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [RES_WIDTH:0] res_sr;

    assign dbg_state = state;

    // Output stream: ser_out is meaningful only while out_valid is high. There is no
    // backpressure: the consumer must take one bit per cycle, and out_done follows the last bit.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            res_sr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            mac_start <= 1'b0;
            in_done   <= 1'b0;
            ser_out   <= 1'b0;
            out_valid <= 1'b0;
            out_done  <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mac_start <= 1'b0;
            in_done   <= 1'b0;
            out_done  <= 1'b0;
            ser_out   <= 1'b0;
            out_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_SHIFT_IN;
                        cnt   <= '0;
                        err   <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_SHIFT_IN: begin
                    op_a <= {op_a[OP_WIDTH-2:0], ser_a};
                    op_b <= {op_b[OP_WIDTH-2:0], ser_b};
                    if (cnt == IN_LAST) begin
                        state     <= S_LAUNCH;
                        mac_start <= 1'b1;
                        in_done   <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_LAUNCH: begin
                    state <= S_WAIT;
                    cnt   <= '0;
                end
                S_WAIT: begin
                    // Finish takes priority over a timeout landing on the same edge.
                    if (mac_finish) begin
                        state     <= S_SHIFT_OUT;
                        res_sr    <= {1'b0, mac_carry, mac_result[RES_WIDTH-1:1]};
                        ser_out   <= mac_result[0];
                        out_valid <= 1'b1;
                        cnt       <= CNT_ONE;
                    end else if (cnt == TMO_LAST) begin
                        state <= S_IDLE;
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_SHIFT_OUT: begin
                    // cnt counts bits already presented; bit 0 went out on the capture edge.
                    if (cnt == OUT_LAST) begin
                        state    <= S_DONE;
                        out_done <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        ser_out   <= res_sr[0];
                        out_valid <= 1'b1;
                        res_sr    <= {1'b0, res_sr[RES_WIDTH:1]};
                        cnt       <= cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_serial_sequencer.sv
// Bench for mac_serial_sequencer: directed transactions with a timeline model of expected outputs,
// checked every cycle on two instances (default timeout and TIMEOUT=4).
module tb_mac_serial_sequencer;

    localparam int OPW   = 8;
    localparam int RESW  = 20;
    localparam int TMO_A = 255;
    localparam int TMO_B = 4;
    localparam int FLD_W = 23;
    localparam int EXP_W = FLD_W + 1;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a_n, rst_b_n;
    logic            start, ser_a, ser_b, mac_finish, mac_carry;
    logic [RESW-1:0] mac_result;

    logic [OPW-1:0] a_op_a, a_op_b, b_op_a, b_op_b;
    logic a_ms, a_id, a_so, a_ov, a_od, a_busy, a_err;
    logic b_ms, b_id, b_so, b_ov, b_od, b_busy, b_err;
    logic [2:0] a_dbg, b_dbg;

    mac_serial_sequencer #(.OP_WIDTH(OPW), .RES_WIDTH(RESW), .TIMEOUT(TMO_A)) dut_a (
        .clk(clk), .reset_n(rst_a_n), .start(start), .ser_a(ser_a), .ser_b(ser_b),
        .mac_finish(mac_finish), .mac_result(mac_result), .mac_carry(mac_carry),
        .op_a(a_op_a), .op_b(a_op_b), .mac_start(a_ms), .in_done(a_id), .ser_out(a_so),
        .out_valid(a_ov), .out_done(a_od), .busy(a_busy), .err(a_err), .dbg_state(a_dbg)
    );

    mac_serial_sequencer #(.OP_WIDTH(OPW), .RES_WIDTH(RESW), .TIMEOUT(TMO_B)) dut_b (
        .clk(clk), .reset_n(rst_b_n), .start(start), .ser_a(ser_a), .ser_b(ser_b),
        .mac_finish(mac_finish), .mac_result(mac_result), .mac_carry(mac_carry),
        .op_a(b_op_a), .op_b(b_op_b), .mac_start(b_ms), .in_done(b_id), .ser_out(b_so),
        .out_valid(b_ov), .out_done(b_od), .busy(b_busy), .err(b_err), .dbg_state(b_dbg)
    );

    int checks   = 0;
    int failures = 0;

    // Expected queue: {active_sel, op_a, op_b, mac_start, in_done, ser_out, out_valid, out_done, busy, err}
    logic [EXP_W-1:0] exp_q[$];
    bit               active;
    logic [OPW-1:0]   m_op_a, m_op_b;
    logic             m_err;

    // scoreboard observations of the active instance
    int          cnt_ov, cnt_od, cnt_ms, cnt_id;
    logic [20:0] cap_bits;

    function automatic logic [FLD_W-1:0] pkf(input logic [7:0] oa, input logic [7:0] ob,
                                             input logic ms, input logic id, input logic so,
                                             input logic ov, input logic od, input logic bz,
                                             input logic er);
        return {oa, ob, ms, id, so, ov, od, bz, er};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input string p, input logic [FLD_W-1:0] act, input logic [FLD_W-1:0] exp);
        chk({p, ".op_a"},      32'(act[22:15]), 32'(exp[22:15]));
        chk({p, ".op_b"},      32'(act[14:7]),  32'(exp[14:7]));
        chk({p, ".mac_start"}, 32'(act[6]),     32'(exp[6]));
        chk({p, ".in_done"},   32'(act[5]),     32'(exp[5]));
        chk({p, ".ser_out"},   32'(act[4]),     32'(exp[4]));
        chk({p, ".out_valid"}, 32'(act[3]),     32'(exp[3]));
        chk({p, ".out_done"},  32'(act[2]),     32'(exp[2]));
        chk({p, ".busy"},      32'(act[1]),     32'(exp[1]));
        chk({p, ".err"},       32'(act[0]),     32'(exp[0]));
    endtask

    // compare process: active instance against the model, idle instance held in reset must read zero
    logic [EXP_W-1:0] e_cur;
    logic [FLD_W-1:0] av, bv, sel;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_cur = exp_q.pop_front();
            av = {a_op_a, a_op_b, a_ms, a_id, a_so, a_ov, a_od, a_busy, a_err};
            bv = {b_op_a, b_op_b, b_ms, b_id, b_so, b_ov, b_od, b_busy, b_err};
            cmp_dut("dut_a", av, e_cur[EXP_W-1] ? '0 : e_cur[FLD_W-1:0]);
            cmp_dut("dut_b", bv, e_cur[EXP_W-1] ? e_cur[FLD_W-1:0] : '0);
            sel = e_cur[EXP_W-1] ? bv : av;
            if (sel[3] === 1'b1) begin
                if (cnt_ov < 21) cap_bits[cnt_ov] = sel[4];
                cnt_ov++;
            end
            if (sel[2] === 1'b1) cnt_od++;
            if (sel[6] === 1'b1) cnt_ms++;
            if (sel[5] === 1'b1) cnt_id++;
        end
    end

    // driver tasks
    task automatic step(input logic [FLD_W-1:0] f);
        @(posedge clk);
        #1;
        exp_q.push_back({active, f});
    endtask

    task automatic clear_sb();
        cnt_ov = 0; cnt_od = 0; cnt_ms = 0; cnt_id = 0; cap_bits = '0;
    endtask

    task automatic idle(input int n, input bit fin_noise);
        for (int i = 0; i < n; i++) begin
            start = 1'b0;
            mac_finish = fin_noise ? ~i[0] : 1'b0;
            step(pkf(m_op_a, m_op_b, 0, 0, 0, 0, 0, 0, m_err));
        end
        mac_finish = 1'b0;
    endtask

    // One transaction as seen from the pins. fin_k: WAIT cycle carrying mac_finish (0 = never);
    // abort_at: result bit index after which reset is applied (0 = no abort).
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b, input int fin_k,
                           input logic [RESW-1:0] res, input logic car, input int tmo,
                           input bit hold, input bit noise, input int abort_at);
        logic [20:0] word;
        bit          got;
        word = {car, res};
        mac_finish = 1'b0;
        mac_result = ~res;
        mac_carry  = ~car;
        start = 1'b1;
        m_err = 1'b0;
        step(pkf(m_op_a, m_op_b, 0, 0, 0, 0, 0, 1, 0));
        for (int i = OPW - 1; i >= 0; i--) begin
            start = hold ? 1'b1 : (noise ? i[0] : 1'b0);
            ser_a = a[i];
            ser_b = b[i];
            m_op_a = {m_op_a[6:0], a[i]};
            m_op_b = {m_op_b[6:0], b[i]};
            step(pkf(m_op_a, m_op_b, i == 0, i == 0, 0, 0, 0, 1, 0));
        end
        ser_a = ~a[0];
        ser_b = ~b[0];
        step(pkf(m_op_a, m_op_b, 0, 0, 0, 0, 0, 1, 0));
        got = 1'b0;
        for (int k = 1; k <= tmo && !got; k++) begin
            if (!hold) start = noise ? k[0] : 1'b0;
            if (k == fin_k) begin
                mac_finish = 1'b1;
                mac_result = res;
                mac_carry  = car;
                step(pkf(m_op_a, m_op_b, 0, 0, word[0], 1, 0, 1, 0));
                got = 1'b1;
            end else if (k == tmo) begin
                m_err = 1'b1;
                step(pkf(m_op_a, m_op_b, 0, 0, 0, 0, 0, 0, 1));
            end else begin
                step(pkf(m_op_a, m_op_b, 0, 0, 0, 0, 0, 1, 0));
            end
        end
        if (!hold) start = 1'b0;
        if (got) begin
            mac_finish = 1'b0;
            mac_result = ~res;
            mac_carry  = ~car;
            for (int j = 1; j <= RESW && abort_at >= 0; j++) begin
                step(pkf(m_op_a, m_op_b, 0, 0, word[j], 1, 0, 1, 0));
                if (j == abort_at) begin
                    if (active) rst_b_n = 1'b0; else rst_a_n = 1'b0;
                    m_op_a = '0; m_op_b = '0; m_err = 1'b0;
                    step(pkf(0, 0, 0, 0, 0, 0, 0, 0, 0));
                    if (active) rst_b_n = 1'b1; else rst_a_n = 1'b1;
                    abort_at = -1;
                end
            end
            if (abort_at >= 0) begin
                step(pkf(m_op_a, m_op_b, 0, 0, 0, 0, 1, 1, 0));
                step(pkf(m_op_a, m_op_b, 0, 0, 0, 0, 0, 0, 0));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0; start = 1'b0; ser_a = 1'b0; ser_b = 1'b0;
        mac_finish = 1'b0; mac_result = '0; mac_carry = 1'b0;
        active = 1'b0; m_op_a = '0; m_op_b = '0; m_err = 1'b0;
        clear_sb();

        step('0);
        step('0);
        chk("reset busy", 32'(a_busy), 32'd0);
        chk("reset op_a", 32'(a_op_a), 32'd0);
        rst_a_n = 1'b1;
        idle(4, 1'b1);

        // operands A5/3C, finish on the 5th WAIT cycle
        clear_sb();
        run_txn(8'hA5, 8'h3C, 5, 20'h1F2E3, 1'b1, TMO_A, 1'b0, 1'b0, 0);
        chk("txn1 op_a", 32'(a_op_a), 32'hA5);
        chk("txn1 op_b", 32'(a_op_b), 32'h3C);
        chk("txn1 stream", 32'(cap_bits), 32'h11F2E3);
        chk("txn1 valid cycles", 32'(cnt_ov), 32'd21);
        chk("txn1 out_done pulses", 32'(cnt_od), 32'd1);
        chk("txn1 mac_start pulses", 32'(cnt_ms), 32'd1);
        chk("txn1 in_done pulses", 32'(cnt_id), 32'd1);

        // start toggling during SHIFT_IN/WAIT is ignored
        clear_sb();
        run_txn(8'h5A, 8'hC3, 3, 20'hABCDE, 1'b0, TMO_A, 1'b0, 1'b1, 0);
        chk("noise stream", 32'(cap_bits), 32'h0ABCDE);
        chk("noise mac_start pulses", 32'(cnt_ms), 32'd1);
        idle(3, 1'b1);

        // back-to-back with start held high
        clear_sb();
        run_txn(8'hFF, 8'hFF, 2, 20'h00001, 1'b1, TMO_A, 1'b1, 1'b0, 0);
        chk("b2b first op_a", 32'(a_op_a), 32'hFF);
        run_txn(8'h01, 8'h02, 1, 20'h80000, 1'b0, TMO_A, 1'b0, 1'b0, 0);
        chk("b2b second op_a", 32'(a_op_a), 32'h01);
        chk("b2b second op_b", 32'(a_op_b), 32'h02);
        chk("b2b out_done pulses", 32'(cnt_od), 32'd2);
        idle(2, 1'b0);

        // reset while bit 7 is on ser_out
        clear_sb();
        run_txn(8'h33, 8'h44, 1, 20'h5A5A5, 1'b1, TMO_A, 1'b0, 1'b0, 7);
        idle(3, 1'b0);
        chk("abort out_done pulses", 32'(cnt_od), 32'd0);
        chk("abort valid cycles", 32'(cnt_ov), 32'd8);
        chk("abort busy", 32'(a_busy), 32'd0);

        // move to the TIMEOUT=4 instance
        active = 1'b1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b1;
        idle(2, 1'b0);
        clear_sb();
        run_txn(8'h12, 8'h34, 0, 20'h12345, 1'b1, TMO_B, 1'b0, 1'b0, 0);
        chk("timeout err", 32'(b_err), 32'd1);
        chk("timeout busy", 32'(b_busy), 32'd0);
        chk("timeout valid cycles", 32'(cnt_ov), 32'd0);
        idle(2, 1'b1);

        // finish on the same edge as the timeout: finish wins, err cleared by start
        clear_sb();
        run_txn(8'h81, 8'h7E, 4, 20'hF0F0F, 1'b0, TMO_B, 1'b0, 1'b0, 0);
        chk("tie err", 32'(b_err), 32'd0);
        chk("tie stream", 32'(cap_bits), 32'h0F0F0F);
        chk("tie valid cycles", 32'(cnt_ov), 32'd21);
        idle(2, 1'b0);

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
